instr_prefetch_unit: RTL and testbench
======================================

INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

Interface
REQ-001 Parameter ADDR_W, default 32, PC/address width; SHALL be 28 or greater.
REQ-002 Parameter RESET_PC, default 32'h00400000, first fetch address after reset.
REQ-003 Parameter QUEUE_DEPTH, default 4, prefetch queue entries; SHALL be a power of 2 and at least 2.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 imem_req  out  1  instruction-memory read strobe.
REQ-007 imem_addr  out  ADDR_W  read address, word aligned.
REQ-008 imem_rdata  in  32  read data; valid exactly one cycle after imem_req.
REQ-009 redirect  in  1  control-flow change request.
REQ-010 npc_sel  in  2  target mode: 0 seq, 1 branch, 2 jump, 3 register.
REQ-011 br_pc  in  ADDR_W  PC of the redirecting instruction.
REQ-012 imm16  in  16  branch offset in words.
REQ-013 target26  in  26  jump target field.
REQ-014 jr_target  in  ADDR_W  register-jump target.
REQ-015 instr_valid  out  1  queue head is valid.
REQ-016 instr  out  32  head instruction.
REQ-017 instr_pc  out  ADDR_W  head instruction address.
REQ-018 instr_ready  in  1  decode accepts the head.
REQ-019 misalign_err  out  1  one-cycle pulse on a misaligned register target.

Function
REQ-020 fetch_pc SHALL issue imem_req with imem_addr=fetch_pc whenever occupancy plus in-flight is below QUEUE_DEPTH, no redirect is present, and rst is low; fetch_pc then advances by 4, modulo 2^ADDR_W.
REQ-021 The response SHALL be written to the tail in the cycle after the request, with its PC; instr_valid SHALL rise no earlier than two cycles after the request.
REQ-022 A pop SHALL occur when instr_valid and instr_ready are both high; a simultaneous push and pop SHALL leave occupancy unchanged, including when the queue is full.
REQ-023 Outputs instr, instr_pc and instr_valid SHALL be driven from registered queue state; there is no combinational path from imem_rdata.
REQ-024 Redirect targets: sel 0 is br_pc+4; sel 1 is br_pc+4+(sext(imm16)<<2); sel 2 is {(br_pc+4)[ADDR_W-1:28], target26, 2'b00}; sel 3 is {jr_target[ADDR_W-1:2], 2'b00}. All arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-025 On redirect, the next cycle SHALL have fetch_pc set to the target and the queue flushed; imem_req SHALL be 0 in the redirect cycle; a response arriving in the redirect cycle SHALL be discarded; a pop in the redirect cycle SHALL still be honoured.
REQ-026 misalign_err SHALL pulse for one cycle when redirect is high, npc_sel is 3, and jr_target[1:0] is nonzero.
REQ-027 A queue pointer SHALL wrap from QUEUE_DEPTH-1 to 0; there is no overflow, because issue is throttled by REQ-020.

Reset
REQ-028 When rst is high at a clock edge, the unit SHALL set fetch_pc to RESET_PC, clear the queue and in-flight flag, set instr_valid, imem_req and misalign_err to 0, and set instr and instr_pc to 0.
REQ-029 rst SHALL take priority over redirect and responses; a response that returns in the first cycle after reset SHALL be discarded.
REQ-030 The first imem_req SHALL occur in the first cycle that rst is low, at RESET_PC.

Configuration
REQ-031 Macro IFETCH_PERF_CNT_EN, when defined, SHALL add two outputs, each 32 bits and reset to 0, both wrapping: fetch_cnt, which counts imem_req cycles, and stall_cnt, which counts cycles where instr_valid is high and instr_ready is low.
REQ-032 When IFETCH_PERF_CNT_EN is undefined, fetch_cnt and stall_cnt SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Reset release with instr_ready=1 and memory returning the address as data: imem_addr SHALL follow 0x00400000, 0x00400004, ..., and instr_valid SHALL rise at cycle 2 with instr=instr_pc=0x00400000.
REQ-034 instr_ready=0 for 10 cycles: exactly 4 requests SHALL issue, the queue SHALL hold 0x00400000..0x0040000C, and the order SHALL be intact after ready rises.
REQ-035 Redirect with sel 1, br_pc=0x00400010 and imm16=16'hFFFE: the next fetch SHALL be at 0x0040000C, the queue SHALL be flushed, and the in-flight word SHALL be dropped.
REQ-036 Redirect with sel 2, br_pc=0x00400020 and target26=26'h0100008: fetch SHALL resume at 0x00400020; a sel 3 redirect with jr_target=0x00400013 SHALL fetch 0x00400010 and pulse misalign_err.
REQ-037 br_pc=0xFFFFFFFC with sel 0: the target SHALL be 0x00000000.
REQ-038 Assert rst mid-stream with the queue full: the next cycle SHALL have instr_valid=0; after release, fetch SHALL restart at 0x00400000; with the macro defined, fetch_cnt and stall_cnt SHALL be 0.

Source files
------------

// File: rtl/instr_prefetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the decode-facing
// head-of-queue handshake.
interface instr_prefetch_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch queue with redirect handling and one-cycle memory latency.
// Optional macro IFETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
module instr_prefetch_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'h0040_0000),
  parameter int unsigned       QUEUE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  instr_prefetch_if.master    bus,
  input  logic                redirect,
  input  logic [1:0]          npc_sel,
  input  logic [ADDR_W-1:0]   br_pc,
  input  logic [15:0]         imm16,
  input  logic [25:0]         target26,
  input  logic [ADDR_W-1:0]   jr_target,
  output logic                misalign_err
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [31:0]       r_q_instr [QUEUE_DEPTH];
  logic [ADDR_W-1:0] r_q_pc    [QUEUE_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic              r_inflight;
  logic              r_misalign;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;

  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_target;
  logic [CNT_W-1:0]  w_count_nxt;

  // Redirect target selection; everything wraps at ADDR_W bits.
  always_comb begin
    w_seq    = br_pc + ADDR_W'(4);
    w_target = w_seq;
    case (npc_sel)
      2'd1:    w_target = w_seq + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
      2'd2:    w_target = (w_seq & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({target26, 2'b00});
      2'd3:    w_target = {jr_target[ADDR_W-1:2], 2'b00};
      default: w_target = w_seq;
    endcase
  end

  // Issue only when the in-flight word is guaranteed a queue slot.
  always_comb begin
    w_req       = !rst && !redirect &&
                  ((r_count + CNT_W'(r_inflight)) < CNT_W'(QUEUE_DEPTH));
    w_push      = r_inflight && !redirect;
    w_pop       = r_valid && bus.instr_ready;
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_q_instr[r_rptr];
  assign bus.instr_pc    = r_q_pc[r_rptr];
  assign misalign_err    = r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_valid       <= 1'b0;
      r_misalign    <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else begin
      r_misalign <= redirect && (npc_sel == 2'd3) && (jr_target[1:0] != 2'b00);
      if (redirect) begin
        // Flush: the response arriving now belongs to the abandoned path.
        r_fetch_pc <= w_target;
        r_inflight <= 1'b0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_valid    <= 1'b0;
      end else begin
        r_inflight    <= w_req;
        r_inflight_pc <= r_fetch_pc;
        if (w_req) begin
          r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        end
        if (w_push) begin
          r_q_instr[r_wptr] <= bus.imem_rdata;
          r_q_pc[r_wptr]    <= r_inflight_pc;
          r_wptr            <= r_wptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_W'(1);
        end
        r_count <= w_count_nxt;
        r_valid <= (w_count_nxt != '0);
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_req) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (r_valid && !bus.instr_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit: directed scenarios then random
// redirects/stalls/resets checked against a queue-level reference model.
module tb_instr_prefetch_unit;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [1:0]  npc_sel = 2'd0;
  logic [31:0] br_pc = '0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic [31:0] jr_target = '0;
  logic        misalign_err;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  instr_prefetch_if #(.ADDR_W(ADDR_W)) bus ();

  instr_prefetch_unit #(
    .ADDR_W(ADDR_W), .RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .redirect(redirect), .npc_sel(npc_sel), .br_pc(br_pc), .imm16(imm16),
    .target26(target26), .jr_target(jr_target), .misalign_err(misalign_err)
`ifdef IFETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] memk = '0;

  // Reference-model state.
  logic [31:0] m_pc = RST_PC;
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = '0;
  logic        m_flush = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_req = 1'b0;
  int          m_occ = 0;
  logic        mem_req_q = 1'b0;
  logic [31:0] mem_addr_q = '0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_stall = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ memk;
  endfunction

  function automatic logic [31:0] target_of(input logic [1:0] sel, input logic [31:0] br,
                                            input logic [15:0] imm, input logic [25:0] t26,
                                            input logic [31:0] jr);
    logic [31:0] seq;
    logic [31:0] off;
    seq = br + 32'd4;
    off = {{16{imm[15]}}, imm};
    if (sel == 2'd0) return seq;
    if (sel == 2'd1) return seq + (off << 2);
    if (sel == 2'd2) return {seq[31:28], t26, 2'b00};
    return {jr[31:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: data for the previous cycle's request is presented this cycle.
  always @(negedge clk) begin
    bus.imem_rdata = mem_req_q ? memf(mem_addr_q) : $urandom;
  end

  // Reference model: request issue, fetch addresses, queue contents, error pulse.
  always begin
    @(negedge clk);
    #1;
    if (m_flush) begin
      exp_q.delete();
      m_flush = 1'b0;
    end
    m_occ = exp_q.size();
    m_req = !rst && !redirect && ((m_occ + (m_infl ? 1 : 0)) < DEPTH);
    chk("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
`ifdef IFETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("stall_cnt", stall_cnt, m_stall);
    if (rst) begin
      m_fetch = '0;
      m_stall = '0;
    end else begin
      m_fetch = m_fetch + (m_req ? 32'd1 : 32'd0);
      m_stall = m_stall + ((m_occ > 0 && !bus.instr_ready) ? 32'd1 : 32'd0);
    end
`endif
    if (m_infl && !rst && !redirect) exp_q.push_back('{pc: m_infl_pc, data: memf(m_infl_pc)});
    m_mis = !rst && redirect && (npc_sel == 2'd3) && (jr_target[1:0] != 2'b00);
    if (rst) begin
      m_pc = RST_PC; m_flush = 1'b1; m_infl = 1'b0;
    end else if (redirect) begin
      m_pc = target_of(npc_sel, br_pc, imm16, target26, jr_target);
      m_flush = 1'b1; m_infl = 1'b0;
    end else begin
      m_infl = m_req; m_infl_pc = m_pc;
      if (m_req) m_pc = m_pc + 32'd4;
    end
    mem_req_q  = bus.imem_req;
    mem_addr_q = bus.imem_addr;
  end

  // Monitor: head-valid check every cycle, contents check on each pop.
  always begin
    @(negedge clk);
    #2;
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_occ > 0));
    if (!rst && bus.instr_valid && bus.instr_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pop_empty: got pc 0x%08h, expected no entry", bus.instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("instr_pc", bus.instr_pc, mon_e.pc);
        chk("instr", bus.instr, mon_e.data);
      end
    end
  end

  task automatic do_reset(input logic rdy, input logic [31:0] key);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; bus.instr_ready = rdy; memk = key;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic redir(input logic [1:0] sel, input logic [31:0] br, input logic [15:0] imm,
                       input logic [25:0] t26, input logic [31:0] jr);
    @(negedge clk);
    redirect = 1'b1; npc_sel = sel; br_pc = br; imm16 = imm; target26 = t26; jr_target = jr;
    #3;
    chk("redir_cycle_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #3;
  endtask

  int nreq;

  initial begin
    bus.instr_ready = 1'b1;
    // Reset release, memory returns the address as data.
    do_reset(1'b1, 32'h0);
    #3;
    chk("c0_addr", bus.imem_addr, RST_PC);
    chk("c0_req", 32'(bus.imem_req), 32'd1);
    chk("c0_instr", bus.instr, 32'h0);
    chk("c0_instr_pc", bus.instr_pc, 32'h0);
    @(negedge clk); #3;
    chk("c1_addr", bus.imem_addr, RST_PC + 32'd4);
    chk("c1_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk); #3;
    chk("c2_valid", 32'(bus.instr_valid), 32'd1);
    chk("c2_instr", bus.instr, RST_PC);
    chk("c2_instr_pc", bus.instr_pc, RST_PC);
    chk("c2_addr", bus.imem_addr, RST_PC + 32'd8);
    repeat (4) @(negedge clk);

    // Decode stalled for 10 cycles from reset release.
    do_reset(1'b0, 32'h0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (bus.imem_req) nreq++;
      @(negedge clk);
    end
    chk("stall_req_count", 32'(nreq), 32'd4);
    #3;
    chk("stall_head_pc", bus.instr_pc, RST_PC);
    @(negedge clk);
    bus.instr_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Branch backwards with words in flight.
    redir(2'd1, 32'h0040_0010, 16'hFFFE, 26'h0, 32'h0);
    chk("br_addr", bus.imem_addr, 32'h0040_000C);
    chk("br_flush_valid", 32'(bus.instr_valid), 32'd0);
    repeat (3) @(negedge clk);
    redir(2'd2, 32'h0040_0020, 16'h0, 26'h010_0008, 32'h0);
    chk("jmp_addr", bus.imem_addr, 32'h0040_0020);
    repeat (3) @(negedge clk);
    redir(2'd3, 32'h0, 16'h0, 26'h0, 32'h0040_0013);
    chk("jr_addr", bus.imem_addr, 32'h0040_0010);
    chk("jr_misalign", 32'(misalign_err), 32'd1);
    repeat (3) @(negedge clk);
    redir(2'd0, 32'hFFFF_FFFC, 16'h0, 26'h0, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    repeat (3) @(negedge clk);

    // Reset with the queue full.
    bus.instr_ready = 1'b0;
    repeat (8) @(negedge clk);
    #3;
    chk("full_valid", 32'(bus.instr_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_req", 32'(bus.imem_req), 32'd1);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
`endif

    // Randomized traffic with a data pattern distinct from the address.
    do_reset(1'b1, 32'h1357_9BDF);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      redirect  = ($urandom_range(0, 15) == 0);
      npc_sel   = 2'($urandom);
      br_pc     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
      imm16     = 16'($urandom);
      target26  = 26'($urandom);
      jr_target = $urandom;
      bus.instr_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 1'b0; redirect = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
